// File: rtl/pn_seq.sv
// -----------------------------------------------------------------------------
// pn_seq -- free-running Fibonacci LFSR pseudo-noise chip generator
//
// Purpose:
//   Produces one PN chip per clock from a WIDTH-bit Fibonacci LFSR. The
//   feedback bit is the XOR of the state bits selected by TAPS. It shifts in
//   at bit 0 while the state moves left. The chip is the state MSB, taken
//   straight from the register, so it is glitch-free.
//
// Parameters:
//   WIDTH : LFSR length in bits (3..32)
//   TAPS  : feedback mask, bit i set => state bit i feeds the XOR
//   SEED  : state loaded while reset is asserted
//
// Ports:
//   clk   : input  1  sole clock, rising edge
//   rst_n : input  1  synchronous active-low reset, loads SEED
//   pn    : output 1  PN chip stream (state MSB)
//
// Build option:
//   PN_SEQ_LOCKUP_GUARD_EN -- when defined, an all-zero state is replaced on
//   the next edge. The replacement is SEED, or 1 in the LSB if SEED is zero.
//   When undefined, an all-zero state persists.
//   This recovers from SEED=0 or an upset.
// -----------------------------------------------------------------------------
module pn_seq #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
  input  logic clk,
  input  logic rst_n,
  output logic pn
);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic             fb;

  // Feedback is taken from the current state only.
  assign fb = ^(s_q & TAPS);

  always_comb begin
    s_d = {s_q[WIDTH-2:0], fb};
`ifdef PN_SEQ_LOCKUP_GUARD_EN
    // The all-zero state is a fixed point of any XOR-feedback LFSR.
    // Leave it by reloading SEED, or a single 1 if SEED itself is zero.
    if (s_q == '0) begin
      if (SEED != '0) s_d = SEED;
      else            s_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) s_q <= SEED;
    else        s_q <= s_d;
  end

  assign pn = s_q[WIDTH-1];

endmodule

// File: tb/tb_pn_seq.sv
`timescale 1ns/1ps
module tb_pn_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pn_def, pn_w7, pn_zero;

  // 10 us clock period
  always #5000 clk = ~clk;

  pn_seq u_def (.clk(clk), .rst_n(rst_n), .pn(pn_def));

  pn_seq #(.WIDTH(7), .TAPS(7'b1100000), .SEED(7'b0000001))
    u_w7 (.clk(clk), .rst_n(rst_n), .pn(pn_w7));

  pn_seq #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'b00000))
    u_zero (.clk(clk), .rst_n(rst_n), .pn(pn_zero));

`ifdef PN_SEQ_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state (plain integers)
  logic [31:0] m_def, m_w7, m_zero;
  // scoreboard queues of expected chips
  bit q_def[$], q_w7[$], q_zero[$];
  // captured actual chips, for sequence-level properties
  bit act_def[$], act_w7[$], act_zero[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] st, input logic [31:0] taps,
                                            input int w, input bit guard);
    logic [31:0] mask;
    logic [31:0] f;
    mask = (32'h1 << w) - 32'h1;
    if (guard && st == 32'h0) return 32'h1;  // zero seed: recover to LSB=1
    f = 32'($countones(st & taps) % 2);
    return ((st << 1) | f) & mask;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive reset level, advance the model at the edge, push expectations.
  task automatic step(input logic r);
    rst_n = r;
    @(posedge clk);
    if (!r) begin
      m_def = 32'h01; m_w7 = 32'h01; m_zero = 32'h00;
    end else begin
      m_def  = lfsr_next(m_def,  32'h14, 5, 1'b0);
      m_w7   = lfsr_next(m_w7,   32'h60, 7, 1'b0);
      m_zero = lfsr_next(m_zero, 32'h14, 5, GUARD);
    end
    q_def.push_back(m_def[4]);
    q_w7.push_back(m_w7[6]);
    q_zero.push_back(m_zero[4]);
    #1;
  endtask

  // Monitor: pops and compares on the falling edge whenever a chip is expected.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (q_def.size() > 0) begin
        e = q_def.pop_front();
        act_def.push_back(pn_def);
        chk("def_chip", 32'(pn_def), 32'(e));
      end
      if (q_w7.size() > 0) begin
        e = q_w7.pop_front();
        act_w7.push_back(pn_w7);
        chk("w7_chip", 32'(pn_w7), 32'(e));
      end
      if (q_zero.size() > 0) begin
        e = q_zero.pop_front();
        act_zero.push_back(pn_zero);
        chk("zero_chip", 32'(pn_zero), 32'(e));
      end
    end
  end

  function automatic int ones(ref bit a[$], input int first, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (first + i < a.size()) c += int'(a[first + i]);
    return c;
  endfunction

  task automatic clear_act();
    act_def.delete(); act_w7.delete(); act_zero.delete();
  endtask

  initial begin
    logic [5:0] first6;
    logic [4:0] restart5;
    int bad;
    int zero_win;

    // Let the clock run with no reset; nothing is expected yet.
    repeat (2) @(posedge clk);
    #1;

    // Phase 1: single-edge reset then 79 more chips
    clear_act();
    step(1'b0);
    repeat (79) step(1'b1);
    @(negedge clk); #1;
    chk("p1_len", 32'(act_def.size()), 32'd80);
    for (int i = 0; i < 6; i++) first6[5-i] = act_def[i];
    chk("first6", 32'(first6), 32'b000010);
    bad = 0;
    for (int i = 0; i < 31; i++) if (act_def[i] != act_def[i+31]) bad++;
    chk("period31", 32'(bad), 32'd0);
    chk("ones31", 32'(ones(act_def, 0, 31)), 32'd16);
    zero_win = 0;
    for (int s = 0; s < 32; s++) if (ones(act_def, s, 31) == 0) zero_win++;
    chk("no_zero_window", 32'(zero_win), 32'd0);

    // Phase 2: reset for one edge after chip 12
    clear_act();
    repeat (13) step(1'b1);
    step(1'b0);
    repeat (5) step(1'b1);
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) restart5[4-i] = act_def[13+i];
    chk("midrun_restart", 32'(restart5), 32'b00001);

    // Phase 3: reset held three edges, then long run
    clear_act();
    step(1'b0); step(1'b0); step(1'b0);
    repeat (130) step(1'b1);
    @(negedge clk); #1;
    chk("hold_seed", 32'(ones(act_def, 0, 3)), 32'd0);
    // sequence starts at index 2 (last reset edge)
    chk("w7_ones127", 32'(ones(act_w7, 2, 127)), 32'd64);
    bad = 0;
    for (int i = 0; i < 4; i++) if (act_w7[2+i] != act_w7[2+i+127]) bad++;
    chk("w7_period127", 32'(bad), 32'd0);
    if (GUARD) begin
      bad = 0;
      for (int i = 0; i < 31; i++) if (act_zero[3+i] != act_zero[3+i+31]) bad++;
      chk("guard_period31", 32'(bad), 32'd0);
      chk("guard_ones31", 32'(ones(act_zero, 3, 31)), 32'd16);
    end else begin
      chk("lockup_zero40", 32'(ones(act_zero, 2, 40)), 32'd0);
    end

    // Phase 4: random reset pulses
    repeat (200) step($urandom_range(0, 15) != 0);
    @(negedge clk); #1;

    chk("q_def_drained",  32'(q_def.size()),  32'd0);
    chk("q_w7_drained",   32'(q_w7.size()),   32'd0);
    chk("q_zero_drained", 32'(q_zero.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pn_seq.md
PN_SEQ -- requirements
Module: pn_seq

Interface
REQ-001 Parameter WIDTH, default 5, LFSR length in bits; legal range 3..32.
REQ-002 Parameter TAPS, default 5'b10100, feedback mask; bit i=1 means state bit i enters the feedback XOR.
REQ-003 Parameter SEED, default 5'b00001, state loaded on reset.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 Port pn  output  1  PN chip stream, one chip per clk cycle.
REQ-007 No other ports; the block is free-running with no enable or load input.

Function
REQ-008 Internal state s[WIDTH-1:0] is a Fibonacci LFSR register.
REQ-009 Feedback f = XOR-reduce(s AND TAPS), computed from the current state.
REQ-010 Each rising edge with rst_n=1: s <= {s[WIDTH-2:0], f}, a left shift with f entering bit 0.
REQ-011 pn = s[WIDTH-1], driven combinationally from the register with no extra logic stage, so pn is glitch-free and registered.
REQ-012 With defaults (x^5+x^3+1, primitive), the sequence is maximal length: period 31 chips, 16 ones and 15 zeros per period.
REQ-013 For any primitive TAPS and nonzero SEED, the period is 2^WIDTH-1 and the all-zero state is never reached.
REQ-014 With defaults, s follows 00001, 00010, 00100, 01001, 10010, 00101, ...; pn = 0,0,0,0,1,0,...
REQ-015 Latency: the first pn chip (SEED[WIDTH-1]) is valid in the cycle after the reset edge; a new chip appears on every subsequent edge.
REQ-016 Non-primitive TAPS are legal and produce a shorter sequence; the block performs no check on TAPS.

Reset
REQ-017 On any rising edge with rst_n=0: s <= SEED, therefore pn <= SEED[WIDTH-1] (0 with defaults).
REQ-018 Reset asserted mid-sequence: the next edge restarts the sequence from SEED; the prior state is discarded.
REQ-019 While rst_n stays low across several edges, s holds SEED.
REQ-020 Before the first clock edge, state is undefined (X in simulation); the system relies on applying reset.
REQ-021 rst_n is sampled only at clk edges; a pulse with no edge has no effect.

Configuration
REQ-022 Macro PN_SEQ_LOCKUP_GUARD_EN, when defined: on an edge with rst_n=1 and s all-zero, s <= SEED if SEED is nonzero, otherwise s <= 1 in the LSB. This recovers from lock-up caused by SEED=0 or an upset.
REQ-023 Without PN_SEQ_LOCKUP_GUARD_EN: no guard logic exists, and an all-zero state persists forever with pn=0.

Verification
REQ-024 Reset with defaults: rst_n=0 for one edge, then 1 -> pn = 0,0,0,0,1,0 over the first six chips.
REQ-025 Period: run 62 chips after reset -> chips 0..30 equal chips 31..61; 16 ones per 31 chips; no 31-chip window is all zero.
REQ-026 Mid-run reset: assert rst_n=0 for one edge after chip 12 -> the sequence restarts at state 00001 and pn=0,0,0,0,1.
REQ-027 Parameterization: WIDTH=7, TAPS=7'b1100000, SEED=7'b0000001 -> period 127 chips, 64 ones.
REQ-028 Lock-up: SEED=0 -> without the macro, pn stays 0 for 40 chips; with PN_SEQ_LOCKUP_GUARD_EN, the state becomes 00001 one edge after reset releases, and the sequence then has period 31.
REQ-029 Bench timing: a 10 us clock period (5000 ns half-period) with the reset pulse aligned to a rising edge gives the same chip sequence.
